cnn_acc_post_ser: RTL and testbench

//  Post-processing stage directly downstream of the per-output-channel CI accumulators.
//  - Captures one CO-wide vector of channel sums, adds per-channel bias, round-shifts and saturates each lane.
//  - Serializes the CO results one channel per beat over a valid/ready stream toward the output fmap writer.

---
 rtl/cnn_acc_post_ser_pkg.sv | 16 +
 rtl/cnn_acc_post_ser_if.sv | 35 +++
 rtl/cnn_acc_post_ser_requant_lane.sv | 50 +++++
 rtl/cnn_acc_post_ser.sv | 99 +++++++++
 tb/tb_cnn_acc_post_ser.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cnn_acc_post_ser_pkg.sv
// Package for cnn_acc_post_ser: default geometry and FSM state encoding.
// Optional feature macro: CNN_POST_RELU_EN (ReLU after saturation).
package cnn_acc_post_ser_pkg;

  localparam int CO_DEF     = 4;   // output channels per captured vector
  localparam int ACI_BW_DEF = 22;  // incoming channel-sum width (signed)
  localparam int B_BW_DEF   = 16;  // bias width (signed)
  localparam int O_F_BW_DEF = 8;   // output fmap width (signed)
  localparam int SHIFT_DEF  = 8;   // arithmetic right shift after bias add

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } post_state_e;

endpackage

// File: rtl/cnn_acc_post_ser_if.sv
// Stream interface for cnn_acc_post_ser.
//   Input side : i_in_valid / i_in_acc / i_bias -> o_in_ready
//   Output side: o_ot_valid / o_ot_fmap / o_ot_ch / o_ot_last <- i_ot_ready
//   Status     : o_overflow (sticky dropped-vector flag)
// master: the environment driving vectors and consuming beats.
// slave : the post-processing block.
interface cnn_acc_post_ser_if
  import cnn_acc_post_ser_pkg::*;
#(
  parameter int CO     = CO_DEF,
  parameter int ACI_BW = ACI_BW_DEF,
  parameter int B_BW   = B_BW_DEF,
  parameter int O_F_BW = O_F_BW_DEF
);
  logic                    i_in_valid;
  logic [CO*ACI_BW-1:0]    i_in_acc;
  logic [CO*B_BW-1:0]      i_bias;
  logic                    o_in_ready;
  logic                    o_ot_valid;
  logic                    i_ot_ready;
  logic [O_F_BW-1:0]       o_ot_fmap;
  logic [$clog2(CO)-1:0]   o_ot_ch;
  logic                    o_ot_last;
  logic                    o_overflow;

  modport master (
    output i_in_valid, i_in_acc, i_bias, i_ot_ready,
    input  o_in_ready, o_ot_valid, o_ot_fmap, o_ot_ch, o_ot_last, o_overflow
  );

  modport slave (
    input  i_in_valid, i_in_acc, i_bias, i_ot_ready,
    output o_in_ready, o_ot_valid, o_ot_fmap, o_ot_ch, o_ot_last, o_overflow
  );
endinterface

// File: rtl/cnn_acc_post_ser_requant_lane.sv
// cnn_requant_lane: combinational requantization of one channel.
//   i_acc  : signed channel sum
//   i_bias : signed per-channel bias
//   o_res  : (acc + bias), round-shifted by SHIFT, saturated to O_F_BW bits;
//            with CNN_POST_RELU_EN defined, negative results become 0.
module cnn_requant_lane
  import cnn_acc_post_ser_pkg::*;
#(
  parameter int ACI_BW = ACI_BW_DEF,
  parameter int B_BW   = B_BW_DEF,
  parameter int O_F_BW = O_F_BW_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic signed [ACI_BW-1:0] i_acc,
  input  logic signed [B_BW-1:0]   i_bias,
  output logic signed [O_F_BW-1:0] o_res
);
  // Two guard bits: one for the add, one so the rounding offset never wraps.
  localparam int S_W = ((ACI_BW > B_BW) ? ACI_BW : B_BW) + 2;
  localparam logic signed [S_W-1:0] MAXV = S_W'((1 << (O_F_BW - 1)) - 1);
  localparam logic signed [S_W-1:0] MINV = ~MAXV;

  logic signed [S_W-1:0]    s_sum;
  logic signed [S_W-1:0]    s_shf;
  logic signed [O_F_BW-1:0] s_sat;

  assign s_sum = S_W'(i_acc) + S_W'(i_bias);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [S_W-1:0] RND = S_W'(1 << (SHIFT - 1));
      assign s_shf = (s_sum + RND) >>> SHIFT;
    end else begin : g_noround
      assign s_shf = s_sum;
    end
  endgenerate

  always_comb begin
    if (s_shf > MAXV)      s_sat = MAXV[O_F_BW-1:0];
    else if (s_shf < MINV) s_sat = MINV[O_F_BW-1:0];
    else                   s_sat = s_shf[O_F_BW-1:0];
  end

`ifdef CNN_POST_RELU_EN
  assign o_res = s_sat[O_F_BW-1] ? '0 : s_sat;
`else
  assign o_res = s_sat;
`endif

endmodule

// File: rtl/cnn_acc_post_ser.sv
// cnn_acc_post_ser: captures a CO-lane vector of channel sums, requantizes
// every lane (bias, round-shift, saturate, optional ReLU) and serializes the
// results one channel per beat on a valid/ready stream.
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   i_soft_reset : synchronous clear, same effect as reset
//   bus          : cnn_acc_post_ser_if.slave (input vector, output beats, overflow)
// Optional feature macro: CNN_POST_RELU_EN (handled inside cnn_requant_lane).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no vector held; o_in_ready=1, o_ot_valid=0
// ST_SEND | streaming res_q[ch_q]; last beat may hand over to a new vector
module cnn_acc_post_ser
  import cnn_acc_post_ser_pkg::*;
#(
  parameter int CO     = CO_DEF,
  parameter int ACI_BW = ACI_BW_DEF,
  parameter int B_BW   = B_BW_DEF,
  parameter int O_F_BW = O_F_BW_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input logic              clk,
  input logic              reset,
  input logic              i_soft_reset,
  cnn_acc_post_ser_if.slave bus
);
  localparam int CH_W = $clog2(CO);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CO - 1);

  post_state_e state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic signed [O_F_BW-1:0] res_q [CO];
  logic signed [O_F_BW-1:0] res_d [CO];
  logic signed [O_F_BW-1:0] lane_res [CO];
  logic overflow_q, overflow_d;
  logic sending, last_beat, in_ready, accept;

  for (genvar k = 0; k < CO; k++) begin : g_lane
    cnn_requant_lane #(
      .ACI_BW (ACI_BW),
      .B_BW   (B_BW),
      .O_F_BW (O_F_BW),
      .SHIFT  (SHIFT)
    ) u_lane (
      .i_acc  (bus.i_in_acc[k*ACI_BW +: ACI_BW]),
      .i_bias (bus.i_bias[k*B_BW +: B_BW]),
      .o_res  (lane_res[k])
    );
  end

  assign sending   = (state_q == ST_SEND);
  assign last_beat = sending && (ch_q == CH_LAST);
  // Ready also on the consumed last beat so back-to-back vectors see no bubble.
  assign in_ready  = (state_q == ST_IDLE) || (last_beat && bus.i_ot_ready);
  assign accept    = bus.i_in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    res_d      = res_q;
    overflow_d = overflow_q;
    if (accept) begin
      res_d   = lane_res;
      ch_d    = '0;
      state_d = ST_SEND;
    end else if (sending && bus.i_ot_ready) begin
      if (last_beat) begin
        ch_d    = '0;
        state_d = ST_IDLE;
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
    if (bus.i_in_valid && !in_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || i_soft_reset) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < CO; k++) res_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      overflow_q <= overflow_d;
      res_q      <= res_d;
    end
  end

  assign bus.o_in_ready = in_ready;
  assign bus.o_ot_valid = sending;
  assign bus.o_ot_fmap  = res_q[ch_q];
  assign bus.o_ot_ch    = ch_q;
  assign bus.o_ot_last  = last_beat;
  assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_cnn_acc_post_ser.sv
module tb_cnn_acc_post_ser;
  import cnn_acc_post_ser_pkg::*;

  localparam int CO = 4, ACI_BW = 22, B_BW = 16, O_F_BW = 8, SHIFT = 8;

`ifdef CNN_POST_RELU_EN
  localparam int N128 = 0;
  localparam int N1   = 0;
`else
  localparam int N128 = -128;
  localparam int N1   = -1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_soft_reset = 1'b0;

  cnn_acc_post_ser_if #(.CO(CO), .ACI_BW(ACI_BW), .B_BW(B_BW), .O_F_BW(O_F_BW)) bus ();

  cnn_acc_post_ser #(.CO(CO), .ACI_BW(ACI_BW), .B_BW(B_BW), .O_F_BW(O_F_BW), .SHIFT(SHIFT)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_soft_reset (i_soft_reset),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc  [CO];
    int bias [CO];
    int exp  [CO];
  } vec_t;

  vec_t vecs [4];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_vec(input int idx);
    for (int k = 0; k < CO; k++) begin
      bus.i_in_acc[k*ACI_BW +: ACI_BW] = ACI_BW'(vecs[idx].acc[k]);
      bus.i_bias[k*B_BW +: B_BW]       = B_BW'(vecs[idx].bias[k]);
    end
    bus.i_in_valid = 1'b1;
  endtask

  task automatic chk_beat(input string tag, input int idx, input int ch);
    chk({tag, "_valid"}, 32'(bus.o_ot_valid), 1);
    chk({tag, "_fmap"}, $signed(bus.o_ot_fmap), vecs[idx].exp[ch]);
    chk({tag, "_ch"}, 32'(bus.o_ot_ch), ch);
    chk({tag, "_last"}, 32'(bus.o_ot_last), (ch == CO - 1) ? 1 : 0);
  endtask

  // Full vector with ready=1: accept, latency-1 first beat, CO beats, back to idle.
  task automatic run_vec(input int idx);
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.o_in_ready), 1);
    drive_vec(idx);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    for (int b = 0; b < CO; b++) begin
      chk_beat($sformatf("v%0d_b%0d", idx, b), idx, b);
      @(negedge clk);
    end
    chk("end_valid", 32'(bus.o_ot_valid), 0);
  endtask

  initial begin
    vecs[0].acc = '{1000, 383, 384, 0};
    vecs[0].bias = '{24, 0, 0, -128};
    vecs[0].exp = '{4, 1, 2, 0};
    vecs[1].acc = '{100000, -100000, 32512, 32640};
    vecs[1].bias = '{0, 0, 0, 0};
    vecs[1].exp = '{127, N128, 127, 127};
    vecs[2].acc = '{-200, -129, -128, 128};
    vecs[2].bias = '{0, 0, 0, 0};
    vecs[2].exp = '{N1, N1, 0, 1};
    vecs[3].acc = '{2097151, -2097152, 0, -32896};
    vecs[3].bias = '{32767, -32768, 32767, 0};
    vecs[3].exp = '{127, N128, 127, N128};

    bus.i_in_valid = 1'b0;
    bus.i_in_acc   = '0;
    bus.i_bias     = '0;
    bus.i_ot_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.o_ot_valid), 0);
    chk("rst_in_ready", 32'(bus.o_in_ready), 1);
    chk("rst_fmap", 32'(bus.o_ot_fmap), 0);
    chk("rst_ch", 32'(bus.o_ot_ch), 0);
    chk("rst_last", 32'(bus.o_ot_last), 0);
    chk("rst_ovf", 32'(bus.o_overflow), 0);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) run_vec(v);

    // Stall three cycles on ch1.
    @(negedge clk);
    drive_vec(0);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    chk_beat("stall_b0", 0, 0);
    @(negedge clk);
    bus.i_ot_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("stall_hold%0d", i), 0, 1);
      @(negedge clk);
    end
    bus.i_ot_ready = 1'b1;
    chk_beat("stall_b1", 0, 1);
    @(negedge clk);
    chk_beat("stall_b2", 0, 2);
    @(negedge clk);
    chk_beat("stall_b3", 0, 3);
    @(negedge clk);
    chk("stall_end_valid", 32'(bus.o_ot_valid), 0);

    // Back-to-back: new vector on the last-beat handshake.
    drive_vec(0);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    for (int b = 0; b < CO - 1; b++) begin
      chk_beat($sformatf("b2b_a%0d", b), 0, b);
      @(negedge clk);
    end
    chk_beat("b2b_a3", 0, 3);
    drive_vec(2);
    #1;
    chk("b2b_in_ready", 32'(bus.o_in_ready), 1);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    for (int b = 0; b < CO; b++) begin
      chk_beat($sformatf("b2b_b%0d", b), 2, b);
      chk("b2b_ovf", 32'(bus.o_overflow), 0);
      @(negedge clk);
    end
    chk("b2b_end_valid", 32'(bus.o_ot_valid), 0);

    // Dropped vector during ch1 sets sticky overflow.
    drive_vec(0);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    chk_beat("drop_b0", 0, 0);
    @(negedge clk);
    chk_beat("drop_b1", 0, 1);
    drive_vec(1);
    #1;
    chk("drop_in_ready", 32'(bus.o_in_ready), 0);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    chk_beat("drop_b2", 0, 2);
    chk("drop_ovf", 32'(bus.o_overflow), 1);
    @(negedge clk);
    chk_beat("drop_b3", 0, 3);
    @(negedge clk);
    chk("drop_end_valid", 32'(bus.o_ot_valid), 0);
    chk("drop_ovf_sticky", 32'(bus.o_overflow), 1);
    i_soft_reset = 1'b1;
    @(negedge clk);
    i_soft_reset = 1'b0;
    chk("soft_rst_ovf", 32'(bus.o_overflow), 0);

    // Reset mid-frame on ch2.
    drive_vec(3);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    chk_beat("mrst_b0", 3, 0);
    @(negedge clk);
    @(negedge clk);
    chk_beat("mrst_b2", 3, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_valid", 32'(bus.o_ot_valid), 0);
    chk("mrst_in_ready", 32'(bus.o_in_ready), 1);
    chk("mrst_ch", 32'(bus.o_ot_ch), 0);
    run_vec(1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
